// File: rtl/fec_pkg.sv
// Shared definitions for the rate-1/2, K=4 (octal 13/17) convolutional code.
package fec_pkg;

  localparam int unsigned K             = 4;
  localparam logic [K-1:0] G1           = 4'b1011;
  localparam logic [K-1:0] G2           = 4'b1111;
  localparam int unsigned NSTATES       = 8;
  localparam int unsigned SW            = 3;
  localparam int unsigned NBITS_DEFAULT = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACS,
    ST_SELECT,
    ST_TRACE,
    ST_DONE
  } fsm_state_e;

  // Expected coded pair {c1,c2} leaving state s={d_k-1,d_k-2,d_k-3} on input u.
  function automatic logic [1:0] enc_pair(input logic [SW-1:0] s, input logic u);
    logic [K-1:0] r;
    r = {u, s};
    return {^(r & G1), ^(r & G2)};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis node; ties resolve to predecessor x=0.
module viterbi_acs #(
  parameter int unsigned PMW = 8
) (
  input  logic [PMW-1:0] pm0,
  input  logic [PMW-1:0] pm1,
  input  logic [1:0]     bm0,
  input  logic [1:0]     bm1,
  output logic [PMW-1:0] pm_new_c,
  output logic           dec_c
);

  logic [PMW-1:0] sum0;
  logic [PMW-1:0] sum1;

  // Candidate metrics through both predecessors, keep the smaller one.
  always_comb begin
    sum0     = pm0 + PMW'(bm0);
    sum1     = pm1 + PMW'(bm1);
    dec_c    = 1'b0;
    pm_new_c = sum0;
    if (sum1 < sum0) begin
      dec_c    = 1'b1;
      pm_new_c = sum1;
    end
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Block hard-decision Viterbi decoder: full-trellis ACS, survivor store, traceback.
module viterbi_decoder
  import fec_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEFAULT,
  parameter int unsigned PMW   = 8
) (
  input  logic               clck,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*NBITS-1:0] FEC,
  output logic [NBITS-1:0]   data_out,
  output logic [PMW-1:0]     err_metric,
  output logic               busy,
  output logic               status
);

  localparam int unsigned FW       = 2 * NBITS;
  localparam int unsigned CW       = $clog2(NBITS + 1);
  localparam int unsigned HALF     = NSTATES / 2;
  localparam logic [PMW-1:0] PM_INIT = PMW'(1) << (PMW - 1);

  fsm_state_e          state;
  fsm_state_e          state_nxt;
  logic [FW-1:0]       fec_q;
  logic [PMW-1:0]      pm     [NSTATES];
  logic [PMW-1:0]      pm_new [NSTATES];
  logic [NSTATES-1:0]  dec;
  logic [NSTATES-1:0]  surv   [NBITS];
  logic [CW-1:0]       step;
  logic [CW-1:0]       trace_idx;
  logic [SW-1:0]       tb_st;
  logic [SW-1:0]       best;
  logic [1:0]          rx_pair;
  logic                last_acs;
  logic                last_trace;

  assign rx_pair    = fec_q[FW-1 -: 2];
  assign last_acs   = (step == CW'(NBITS));
  assign last_trace = (step == CW'(1));
  assign trace_idx  = CW'(NBITS) - step;

  // One ACS node per next state n={u,n1,n0}; predecessors are {n1,n0,x}.
  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam logic [SW-1:0] P0 = SW'((n % HALF) * 2);
    localparam logic [SW-1:0] P1 = SW'((n % HALF) * 2 + 1);
    localparam logic          U  = 1'(n / HALF);

    logic [1:0] e0;
    logic [1:0] e1;
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign e0  = enc_pair(P0, U) ^ rx_pair;
    assign e1  = enc_pair(P1, U) ^ rx_pair;
    assign bm0 = 2'(e0[1]) + 2'(e0[0]);
    assign bm1 = 2'(e1[1]) + 2'(e1[0]);

    viterbi_acs #(.PMW(PMW)) u_acs (
      .pm0      (pm[P0]),
      .pm1      (pm[P1]),
      .bm0      (bm0),
      .bm1      (bm1),
      .pm_new_c (pm_new[n]),
      .dec_c    (dec[n])
    );
  end

  // Lowest-index state holding the minimum final metric.
  always_comb begin
    best = '0;
    for (int i = 1; i < NSTATES; i++) begin
      if (pm[i] < pm[best]) best = SW'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clck) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a start pulse restarts from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_ACS;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_IDLE;
        ST_ACS:    if (last_acs) state_nxt = ST_SELECT;
        ST_SELECT: state_nxt = ST_TRACE;
        ST_TRACE:  if (last_trace) state_nxt = ST_DONE;
        ST_DONE:   state_nxt = ST_DONE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: frame capture, metric update, survivor writes, traceback, outputs.
  always_ff @(posedge clck) begin
    if (!rst_n) begin
      fec_q      <= '0;
      step       <= '0;
      tb_st      <= '0;
      data_out   <= '0;
      err_metric <= '0;
      busy       <= 1'b0;
      status     <= 1'b0;
      for (int i = 0; i < NSTATES; i++) pm[i] <= '0;
      for (int k = 0; k < NBITS; k++) surv[k] <= '0;
    end else if (start) begin
      fec_q  <= FEC;
      step   <= CW'(1);
      busy   <= 1'b1;
      status <= 1'b0;
      pm[0]  <= '0;
      for (int i = 1; i < NSTATES; i++) pm[i] <= PM_INIT;
    end else begin
      case (state)
        ST_ACS: begin
          for (int i = 0; i < NSTATES; i++) pm[i] <= pm_new[i];
          surv[step - CW'(1)] <= dec;
          fec_q <= fec_q << 2;
          if (!last_acs) step <= step + CW'(1);
        end
        ST_SELECT: begin
          err_metric <= pm[best];
          tb_st      <= best;
          step       <= CW'(NBITS);
        end
        ST_TRACE: begin
          data_out[trace_idx] <= tb_st[SW-1];
          tb_st <= {tb_st[SW-2:0], surv[step - CW'(1)][tb_st]};
          step  <= step - CW'(1);
        end
        ST_DONE: begin
          busy   <= 1'b0;
          status <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed and randomised checks of the Viterbi decoder against a bench encoder.
module tb_viterbi_decoder;

  logic        clck = 1'b0;
  logic        rst_n;
  logic        start;
  logic [95:0] fec;
  logic [47:0] data_out;
  logic [7:0]  err_metric;
  logic        busy;
  logic        status;

  int n_cmp = 0;
  int n_bad = 0;

  viterbi_decoder u_dut (
    .clck       (clck),
    .rst_n      (rst_n),
    .start      (start),
    .FEC        (fec),
    .data_out   (data_out),
    .err_metric (err_metric),
    .busy       (busy),
    .status     (status)
  );

  always #5 clck = ~clck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference rate-1/2 encoder, d_1 in d[47], first pair in f[95:94].
  function automatic logic [95:0] encode(input logic [47:0] d);
    logic [95:0] f;
    logic [2:0]  s;
    logic        u;
    f = '0;
    s = '0;
    for (int k = 1; k <= 48; k++) begin
      u = d[48-k];
      f[2*(48-k)+1] = u ^ s[1] ^ s[0];
      f[2*(48-k)]   = u ^ s[2] ^ s[1] ^ s[0];
      s = {u, s[2], s[1]};
    end
    return f;
  endfunction

  task automatic start_pulse(input logic [95:0] f);
    @(negedge clck);
    fec   = f;
    start = 1'b1;
    @(negedge clck);
    start = 1'b0;
  endtask

  // Cycles after the start edge until status rises; 0 means it never did.
  task automatic wait_status(output int lat, output logic busy1);
    lat   = 0;
    busy1 = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clck);
      #1;
      if (i == 1) busy1 = busy;
      if (status) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_decode(input logic [95:0] f, output int lat, output logic busy1);
    start_pulse(f);
    wait_status(lat, busy1);
  endtask

  initial begin
    int          lat;
    logic        b1;
    logic [47:0] d;
    logic [95:0] f;
    int          nerr;
    int          p1;
    int          p2;

    rst_n = 1'b0;
    start = 1'b0;
    fec   = '0;
    repeat (3) @(posedge clck);
    #1;
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_err", 64'(err_metric), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_status", 64'(status), 64'h0);
    @(negedge clck);
    rst_n = 1'b1;

    // All-zero frame: also checks busy and exact latency.
    run_decode(96'h0, lat, b1);
    chk("zero_busy", 64'(b1), 64'h1);
    chk("zero_lat", 64'(lat), 64'd98);
    chk("zero_data", 64'(data_out), 64'h0);
    chk("zero_err", 64'(err_metric), 64'h0);
    chk("zero_busy_done", 64'(busy), 64'h0);

    // Single leading one: codeword 11 01 11 11 then zeros.
    run_decode(96'hDF00_0000_0000_0000_0000_0000, lat, b1);
    chk("one_lat", 64'(lat), 64'd98);
    chk("one_data", 64'(data_out), 64'h8000_0000_0000);
    chk("one_err", 64'(err_metric), 64'h0);

    // Same frame with FEC[90] flipped.
    run_decode(96'hDB00_0000_0000_0000_0000_0000, lat, b1);
    chk("flip_data", 64'(data_out), 64'h8000_0000_0000);
    chk("flip_err", 64'(err_metric), 64'h1);

    // Random data with 0..2 well-separated errors away from the frame tail.
    for (int t = 0; t < 200; t++) begin
      d    = 48'({$urandom(), $urandom()});
      f    = encode(d);
      nerr = $urandom_range(2, 0);
      p1   = $urandom_range(83, 16);
      p2   = $urandom_range(95, p1 + 12);
      if (nerr >= 1) f[p1] = ~f[p1];
      if (nerr == 2) f[p2] = ~f[p2];
      run_decode(f, lat, b1);
      chk("rand_lat", 64'(lat), 64'd98);
      chk("rand_data", 64'(data_out), 64'(d));
      chk("rand_err", 64'(err_metric), 64'(nerr));
    end

    // Restart 30 cycles into a decode; only the second frame should count.
    start_pulse(encode(48'hFFFF_0000_FFFF));
    repeat (30) @(posedge clck);
    run_decode(encode(48'h1234_5678_9ABC), lat, b1);
    chk("restart_lat", 64'(lat), 64'd98);
    chk("restart_data", 64'(data_out), 64'h1234_5678_9ABC);
    chk("restart_err", 64'(err_metric), 64'h0);

    // Reset in the middle of traceback.
    start_pulse(encode(48'hA5A5_5A5A_C3C3));
    repeat (70) @(posedge clck);
    @(negedge clck);
    rst_n = 1'b0;
    @(posedge clck);
    #1;
    chk("mid_rst_status", 64'(status), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_data", 64'(data_out), 64'h0);
    chk("mid_rst_err", 64'(err_metric), 64'h0);
    @(negedge clck);
    rst_n = 1'b1;
    run_decode(encode(48'h0F1E_2D3C_4B5A), lat, b1);
    chk("post_rst_lat", 64'(lat), 64'd98);
    chk("post_rst_data", 64'(data_out), 64'h0F1E_2D3C_4B5A);
    chk("post_rst_err", 64'(err_metric), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=4 convolutional code (generators G1=1011, G2=1111; octal 13/17), unterminated 48-bit frames.
- Takes one 96-bit coded frame as produced by the transmit-side encoder and recovers the 48 data bits plus a path-metric error count.
- Sits in the receive chain after demodulation/bit slicing and before the frame parser.
- Block-based: 48 ACS cycles over a full trellis with complete survivor storage, then a 48-cycle traceback.

Parameters:
- NBITS, 48, data bits per frame (coded frame = 2*NBITS).
- PMW, 8, path-metric width; must satisfy 2^(PMW-1)+2*NBITS < 2^PMW.

Ports:
- clck  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse: capture FEC and begin decoding.
- FEC  input  2*NBITS  coded frame; pair for step k (k=1..NBITS) is {FEC[2*(NBITS-k)+1], FEC[2*(NBITS-k)]} = {c1,c2}, MSB pair first.
- data_out  output  NBITS  decoded bits; d_1 at data_out[NBITS-1], d_NBITS at data_out[0].
- err_metric  output  PMW  winning final path metric = Hamming distance between received and re-encoded frame.
- busy  output  1  high from the start capture until done.
- status  output  1  high once data_out/err_metric are valid; held until the next start or reset.

Behaviour:
- Reset (rst_n=0 at an edge): FSM=IDLE; data_out=0, err_metric=0, busy=0, status=0; metrics and survivors cleared. Reset overrides start.
- Encoder model: state s={d_{k-1},d_{k-2},d_{k-3}} (s[2]=d_{k-1}), initial state 0. Input u=d_k gives c1=u^s[1]^s[0], c2=u^s[2]^s[1]^s[0]; next state {u,s[2],s[1]}.
- FSM states: IDLE -> ACS -> SELECT -> TRACE -> DONE.
- IDLE / DONE: on start, capture FEC into an internal register.
  - Initialise metrics: PM[0]=0, PM[1..7]=2^(PMW-1).
  - Set step=1, busy=1, status=0, go to ACS.
- Start in any other state aborts the current decode and restarts identically. data_out holds its old value until the new traceback overwrites it.
- ACS: one trellis step per cycle, all 8 states in parallel.
  - Branch metric BM = Hamming distance of the expected {c1,c2} to the received pair, range 0..2.
  - Next state n={u,n1,n0} has predecessors {n1,n0,x} for x in {0,1}.
  - PM'[n] = min over x of PM[{n1,n0,x}] + BM.
  - On a tie, pick x=0.
  - Store survivor bit x into surv[step][n].
  - Leave ACS after step NBITS, i.e. NBITS cycles.
- Metric arithmetic: unsigned PMW bits, no normalisation. The width rule guarantees no overflow.
- SELECT (1 cycle): best = argmin PM, lowest index on tie; err_metric=PM[best].
- TRACE: one step per cycle for k=NBITS down to 1, NBITS cycles.
  - Write data_out[NBITS-k] = state[2].
  - Update state = {state[1], state[0], surv[k][state]}.
- DONE: busy=0, status=1.
- Latency: start sampled at edge E; status=1 and valid outputs after edge E+2*NBITS+2 (E+98 at default).
- No tail bits: the last few data bits have reduced protection. This is accepted and is not an error.

Decomposition:
- Package fec_pkg holds:
  - K=4, G1=4'b1011, G2=4'b1111.
  - NSTATES=8, NBITS default.
  - FSM state enum.
  - A function returning expected {c1,c2} for (state,u).
- The transmit-side encoder shares this package.
- One sub-module, viterbi_acs: combinational add-compare-select for one next-state node (two metrics plus two branch metrics in; new metric and decision bit out), instantiated 8 times.
- Survivor RAM and traceback stay in the top level.

Test Plan:
- FEC=96'h0 -> data_out=48'h0, err_metric=0, status high exactly 98 cycles after start.
- FEC=96'hDF00_0000_0000_0000_0000_0000 (only d_1=1) -> data_out=48'h8000_0000_0000, err_metric=0.
- Same frame with FEC[90] flipped -> data_out=48'h8000_0000_0000, err_metric=1.
- 200 random data words through a reference encoder model with at most 2 bit errors ≥12 coded bits apart, all in FEC[95:16] -> data_out matches, err_metric equals the injected error count.
- Start pulsed again at cycle 30 of a decode -> decode restarts, status high 98 cycles after the second start, result reflects the second FEC.
- rst_n=0 mid-TRACE -> next cycle status=0, busy=0, data_out=0; following start decodes correctly.
